// File: rtl/dm_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
// Used by dm_lsu and dm_lane_merge.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait,
        StResp
    } state_e;

    function automatic logic [31:0] merge_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = '0;
        case (size)
            SZ_BYTE: m = 32'h0000_00ff << {lane, 3'b000};
            SZ_HALF: m = lane[1] ? 32'hffff_0000 : 32'h0000_ffff;
            SZ_WORD: m = 32'hffff_ffff;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational byte-lane store merge and load extraction for one 32-bit word.
// Shared with the cache-fill path.
module dm_lane_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [31:0] mask;
    logic [31:0] placed;

    always_comb begin
        placed = wdata;
        // Replicate the right-aligned data across lanes; the mask picks the live ones.
        case (size)
            SZ_BYTE: placed = {4{wdata[7:0]}};
            SZ_HALF: placed = {2{wdata[15:0]}};
            default: placed = wdata;
        endcase
        mask      = merge_mask(size, lane);
        new_word  = (old_word & ~mask) | (placed & mask);
        load_data = load_extend(old_word, size, lane, is_signed);
    end

endmodule

// File: rtl/dm_lsu.sv
// Data memory with load/store unit for the MEM stage; clears the array after reset.
// Optional store trace is compiled in with DM_LSU_TRACE_EN.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [AW-1:0] init_idx_q;
    logic [3:0]    wait_q;
    logic          lat_we, lat_signed;
    logic [1:0]    lat_size;
    logic [31:0]   lat_addr, lat_wdata;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          enter_resp;

    logic [31:0]   mem [DEPTH];

    // With zero latency RESP is entered on the accept edge, so use the live request there.
    logic          cur_we, cur_signed;
    logic [1:0]    cur_size;
    logic [31:0]   cur_addr, cur_wdata;
    logic [31:0]   offset;
    logic [1:0]    lane;
    logic [AW-1:0] widx;
    logic          acc_err;
    logic [31:0]   old_word, new_word, load_data;
    logic          accept, commit, mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;

    assign cur_we     = (state_q == StIdle) ? req_we     : lat_we;
    assign cur_signed = (state_q == StIdle) ? req_signed : lat_signed;
    assign cur_size   = (state_q == StIdle) ? req_size   : lat_size;
    assign cur_addr   = (state_q == StIdle) ? req_addr   : lat_addr;
    assign cur_wdata  = (state_q == StIdle) ? req_wdata  : lat_wdata;

    assign offset = cur_addr - BASE_ADDR;
    assign lane   = offset[1:0];
    assign widx   = offset[AW+1:2];

    // The below-base test stops a wrapped offset from looking in range.
    assign acc_err = (cur_size == SZ_RSVD)
                   || ((cur_size == SZ_HALF) && lane[0])
                   || ((cur_size == SZ_WORD) && (lane != 2'b00))
                   || (cur_addr < BASE_ADDR)
                   || ({1'b0, offset} >= LIMIT);

    assign old_word = mem[widx];

    dm_lane_merge u_lane_merge (
        .old_word  (old_word),
        .wdata     (cur_wdata),
        .size      (cur_size),
        .lane      (lane),
        .is_signed (cur_signed),
        .new_word  (new_word),
        .load_data (load_data)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            StInit: begin
                if (init_idx_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wait_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            wait_q     <= '0;
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StInit) begin
                init_idx_q <= init_idx_q + 1'b1;
            end
            if (accept) begin
                lat_we     <= req_we;
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                wait_q     <= WAIT_LOAD;
            end else if ((state_q == StWait) && (wait_q != 4'd0)) begin
                wait_q <= wait_q - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (!cur_we && !acc_err) ? load_data : 32'd0;
            end
        end
    end

    assign commit    = enter_resp && cur_we && !acc_err;
    assign mem_we    = !reset && ((state_q == StInit) || commit);
    assign mem_idx   = (state_q == StInit) ? init_idx_q : widx;
    assign mem_wdata = (state_q == StInit) ? 32'd0 : new_word;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

`ifdef DM_LSU_TRACE_EN
    logic [31:0] lat_pc;
    logic [31:0] cur_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_pc <= '0;
        end else if (accept) begin
            lat_pc <= req_pc;
        end
    end

    assign cur_pc = (state_q == StIdle) ? req_pc : lat_pc;

    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            $display("%d@%h: *%h <= %h", $time, cur_pc, {cur_addr[31:2], 2'b00}, new_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// Directed scoreboard bench for dm_lsu with DEPTH=16, LATENCY=2.
module tb_dm_lsu;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned LATENCY = 2;
    localparam logic [1:0]  B = 2'd0, H = 2'd1, W = 2'd2, R = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    dm_lsu #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Counts cycles with req_ready low after reset release; no response may appear meanwhile.
    task automatic init_wait(input string tag);
        int n;
        int seen;
        n = 0;
        seen = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk);
            n++;
        end
        check({tag, " init_cycles"}, 32'(n), 32'(DEPTH));
        check({tag, " no_rsp"}, 32'(seen), 32'd0);
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err, input int hold);
        int n;
        logic [32:0] e;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            check({tag, " ready"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_pc     = 32'h0040_0000 + addr;
        rsp_ready  = (hold == 0);
        sb_q.push_back({exp_err, exp_data});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(LATENCY + 1));
        if (rsp_valid !== 1'b1) begin
            void'(sb_q.pop_front());
            rsp_ready = 1'b1;
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold_err"}, 32'(rsp_err), 32'(e[32]));
            check({tag, " hold_busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check({tag, " rdata"}, rsp_rdata, e[31:0]);
        check({tag, " err"}, 32'(rsp_err), 32'(e[32]));
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        init_wait("boot");

        for (int i = 0; i < int'(DEPTH); i++) begin
            txn("clear", 1'b0, W, 1'b0, 32'(4 * i), 32'd0, 32'd0, 1'b0, 0);
        end

        txn("sw8", 1'b1, W, 1'b0, 32'h8, 32'h1234_5678, 32'd0, 1'b0, 0);
        txn("lw8", 1'b0, W, 1'b0, 32'h8, 32'd0, 32'h1234_5678, 1'b0, 0);
        txn("sbB", 1'b1, B, 1'b0, 32'hB, 32'hFFFF_FFAB, 32'd0, 1'b0, 0);
        txn("lbuB", 1'b0, B, 1'b0, 32'hB, 32'd0, 32'h0000_00AB, 1'b0, 0);
        txn("lbB", 1'b0, B, 1'b1, 32'hB, 32'd0, 32'hFFFF_FFAB, 1'b0, 0);
        txn("lw8m", 1'b0, W, 1'b0, 32'h8, 32'd0, 32'hAB34_5678, 1'b0, 0);
        txn("lbu9", 1'b0, B, 1'b0, 32'h9, 32'd0, 32'h0000_0056, 1'b0, 0);

        txn("sh5", 1'b1, H, 1'b0, 32'h5, 32'h0000_8001, 32'd0, 1'b1, 0);
        txn("lw4a", 1'b0, W, 1'b0, 32'h4, 32'd0, 32'd0, 1'b0, 0);
        txn("sh6", 1'b1, H, 1'b0, 32'h6, 32'h0000_8001, 32'd0, 1'b0, 0);
        txn("lh6", 1'b0, H, 1'b1, 32'h6, 32'd0, 32'hFFFF_8001, 1'b0, 0);
        txn("lhu6", 1'b0, H, 1'b0, 32'h6, 32'd0, 32'h0000_8001, 1'b0, 0);
        txn("lh4", 1'b0, H, 1'b1, 32'h4, 32'd0, 32'd0, 1'b0, 0);
        txn("lw4b", 1'b0, W, 1'b0, 32'h4, 32'd0, 32'h8001_0000, 1'b0, 0);

        txn("lw_oor", 1'b0, W, 1'b0, 32'(4 * DEPTH), 32'd0, 32'd0, 1'b1, 5);
        txn("sw_oor", 1'b1, W, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        txn("sb_last", 1'b1, B, 1'b0, 32'(4 * DEPTH - 1), 32'h0000_007F, 32'd0, 1'b0, 0);
        txn("lb_last", 1'b0, B, 1'b1, 32'(4 * DEPTH - 1), 32'd0, 32'h0000_007F, 1'b0, 0);
        txn("lw_last", 1'b0, W, 1'b0, 32'(4 * DEPTH - 4), 32'd0, 32'h7F00_0000, 1'b0, 0);
        txn("rsvd", 1'b0, R, 1'b0, 32'h8, 32'd0, 32'd0, 1'b1, 0);
        txn("lw_mis", 1'b0, W, 1'b0, 32'h2, 32'd0, 32'd0, 1'b1, 0);
        txn("sw_mis", 1'b1, W, 1'b0, 32'h9, 32'h5555_5555, 32'd0, 1'b1, 0);
        txn("lw8c", 1'b0, W, 1'b0, 32'h8, 32'd0, 32'hAB34_5678, 1'b0, 0);

        // Store dropped by a reset landing in its WAIT phase.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = W;
        req_addr  = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("drop in_wait", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("drop rst_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        init_wait("drop");
        txn("drop lw10", 1'b0, W, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0, 0);
        txn("drop lw8", 1'b0, W, 1'b0, 32'h8, 32'd0, 32'd0, 1'b0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
